// File: rtl/snn_presentation_sequencer_if.sv
// rtl/snn_presentation_sequencer_if.sv - harness/core signal bundle for the SNN presentation sequencer
interface snn_presentation_sequencer_if #(
    parameter int NUM_NEURONS = 100
);
    localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    logic                   start;
    logic [31:0]            present_cycles;
    logic [31:0]            rest_cycles;
    logic [15:0]            min_spikes;
    logic                   image_ack;
    logic [NUM_NEURONS-1:0] exc_spikes;
    logic                   image_req;
    logic                   net_reset;
    logic                   generator_enable;
    logic                   neuron_en;
    logic                   busy;
    logic                   done;
    logic                   winner_valid;
    logic [IDX_W-1:0]       winner_idx;
    logic [15:0]            total_spikes;
    logic [2:0]             intensity_boost;

    modport master (
        output start, present_cycles, rest_cycles, min_spikes, image_ack, exc_spikes,
        input  image_req, net_reset, generator_enable, neuron_en, busy, done,
               winner_valid, winner_idx, total_spikes, intensity_boost
    );

    modport slave (
        input  start, present_cycles, rest_cycles, min_spikes, image_ack, exc_spikes,
        output image_req, net_reset, generator_enable, neuron_en, busy, done,
               winner_valid, winner_idx, total_spikes, intensity_boost
    );
endinterface

// File: rtl/snn_presentation_sequencer.sv
// rtl/snn_presentation_sequencer.sv - per-image load/reset/present/argmax/rest sequencer; optional retry via SNN_SEQ_RETRY_EN
module snn_presentation_sequencer #(
    parameter int NUM_NEURONS = 100,
    parameter int CNT_WIDTH   = 8,
    parameter int MAX_RETRY   = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    snn_presentation_sequencer_if.slave  bus
);
    localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int POP_W = $clog2(NUM_NEURONS + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_NET_RST, S_PRESENT, S_EVAL, S_REST, S_DONE
    } state_t;

    state_t state, state_d;

    logic [31:0]          p_len, r_len, cyc;
    logic [CNT_WIDTH-1:0] cnt [NUM_NEURONS];
    logic [IDX_W-1:0]     scan_idx, best_idx;
    logic [CNT_WIDTH-1:0] best_cnt, scan_cnt;
    logic [POP_W-1:0]     pop;
    logic [16:0]          total_sum;
    logic [15:0]          total_q;
    logic                 retry_take, retry_pend;

    logic                 image_req_q, net_reset_q, gen_en_q, neuron_en_q;
    logic                 busy_q, done_q, winner_valid_q;
    logic [IDX_W-1:0]     winner_idx_q;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            pop = pop + POP_W'(bus.exc_spikes[i]);
        end
    end

    assign total_sum = {1'b0, total_q} + 17'(pop);
    assign scan_cnt  = cnt[scan_idx];

`ifdef SNN_SEQ_RETRY_EN
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    logic [15:0]        min_q;
    logic [RETRY_W-1:0] retry_cnt;
    logic [2:0]         boost_q;

    // Decision uses the final presentation total, evaluated in the last scan cycle.
    assign retry_take = (total_q < min_q) && (retry_cnt < RETRY_W'(MAX_RETRY));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            min_q     <= '0;
            retry_cnt <= '0;
            boost_q   <= '0;
        end else if (state == S_IDLE && bus.start) begin
            min_q     <= bus.min_spikes;
            retry_cnt <= '0;
            boost_q   <= '0;
        end else if (state == S_EVAL && scan_idx == LAST_IDX && retry_take) begin
            retry_cnt <= retry_cnt + RETRY_W'(1);
            boost_q   <= boost_q + 3'd1;
        end
    end

    assign bus.intensity_boost = boost_q;
`else
    assign retry_take          = 1'b0;
    assign bus.intensity_boost = 3'd0;
`endif

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:    if (bus.start) state_d = S_LOAD;
            S_LOAD:    if (bus.image_ack) state_d = S_NET_RST;
            S_NET_RST: state_d = S_PRESENT;
            S_PRESENT: if (cyc >= p_len) state_d = S_EVAL;
            S_EVAL: begin
                if (scan_idx == LAST_IDX) begin
                    if (r_len != 32'd0)  state_d = S_REST;
                    else if (retry_take) state_d = S_NET_RST;
                    else                 state_d = S_DONE;
                end
            end
            S_REST:    if (cyc >= r_len) state_d = retry_pend ? S_NET_RST : S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they switch on the entry edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            p_len          <= '0;
            r_len          <= '0;
            cyc            <= '0;
            scan_idx       <= '0;
            best_idx       <= '0;
            best_cnt       <= '0;
            total_q        <= '0;
            retry_pend     <= 1'b0;
            image_req_q    <= 1'b0;
            net_reset_q    <= 1'b0;
            gen_en_q       <= 1'b0;
            neuron_en_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            winner_valid_q <= 1'b0;
            winner_idx_q   <= '0;
        end else begin
            state       <= state_d;
            image_req_q <= (state_d == S_LOAD);
            net_reset_q <= (state_d == S_NET_RST);
            gen_en_q    <= (state_d == S_PRESENT);
            neuron_en_q <= (state_d == S_PRESENT) || (state_d == S_REST);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
            cyc         <= (state_d != state) ? 32'd1 : cyc + 32'd1;

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        p_len          <= bus.present_cycles;
                        r_len          <= bus.rest_cycles;
                        winner_valid_q <= 1'b0;
                    end
                end
                S_NET_RST: begin
                    total_q    <= '0;
                    scan_idx   <= '0;
                    best_idx   <= '0;
                    best_cnt   <= '0;
                    retry_pend <= 1'b0;
                end
                S_PRESENT: begin
                    total_q <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
                end
                S_EVAL: begin
                    if (scan_cnt > best_cnt) begin
                        best_cnt <= scan_cnt;
                        best_idx <= scan_idx;
                    end
                    if (scan_idx == LAST_IDX) retry_pend <= retry_take;
                    else                      scan_idx   <= scan_idx + IDX_W'(1);
                end
                default: ;
            endcase

            // With R=0 DONE follows EVAL directly, so fold in the last scanned counter here.
            if (state_d == S_DONE) begin
                winner_valid_q <= 1'b1;
                winner_idx_q   <= (state == S_EVAL && scan_cnt > best_cnt) ? scan_idx : best_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) cnt[i] <= '0;
        end else if (state == S_NET_RST) begin
            for (int i = 0; i < NUM_NEURONS; i++) cnt[i] <= '0;
        end else if (state == S_PRESENT) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (bus.exc_spikes[i] && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.image_req        = image_req_q;
    assign bus.net_reset        = net_reset_q;
    assign bus.generator_enable = gen_en_q;
    assign bus.neuron_en        = neuron_en_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.winner_valid     = winner_valid_q;
    assign bus.winner_idx       = winner_idx_q;
    assign bus.total_spikes     = total_q;
endmodule

// File: tb/tb_snn_presentation_sequencer.sv
// tb/tb_snn_presentation_sequencer.sv - self-checking bench for snn_presentation_sequencer
module tb_snn_presentation_sequencer;
    localparam int N         = 100;
    localparam int MAX_RETRY = 4;
`ifdef SNN_SEQ_RETRY_EN
    localparam int RETRY_ON = 1;
`else
    localparam int RETRY_ON = 0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    snn_presentation_sequencer_if #(.NUM_NEURONS(N)) bus();

    snn_presentation_sequencer #(
        .NUM_NEURONS(N),
        .CNT_WIDTH  (8),
        .MAX_RETRY  (MAX_RETRY)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct {
        int p; int r; int ack_dly; int min_sp;
        int na; int ka; int nb; int kb;
        bit all_ones; bit b2b;
        int exp_win; int exp_tot;
    } vec_t;

    typedef struct {
        int lat; int win; int tot; int windows; int boost;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[7];
    int   checks = 0;
    int   errors = 0;
    int   edge_no = 0;
    int   cur_na = 0, cur_ka = 0, cur_nb = 0, cur_kb = 0;
    bit   cur_all = 1'b0;

    always @(posedge clk) edge_no <= edge_no + 1;

    // Spike source: pattern during generator_enable, all-ones noise otherwise.
    initial begin
        int pc;
        logic [N-1:0] v;
        pc = 0;
        bus.exc_spikes = '0;
        forever begin
            @(negedge clk);
            if (bus.generator_enable) begin
                v = '0;
                if (cur_all) v = '1;
                if (pc < cur_ka) v[cur_na] = 1'b1;
                if (pc < cur_kb) v[cur_nb] = 1'b1;
                bus.exc_spikes = v;
                pc++;
            end else begin
                bus.exc_spikes = '1;
                pc = 0;
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint out_vec();
        return {bus.image_req, bus.net_reset, bus.generator_enable, bus.neuron_en, bus.busy,
                bus.done, bus.winner_valid, bus.winner_idx, bus.total_spikes, bus.intensity_boost};
    endfunction

    task automatic run_image(input vec_t v);
        exp_t e, g;
        int pmax, runs, t0, windows, reqs, rests, gen_cycles, max_boost, stall_bad;
        bit got, prev_gen;
        pmax  = (v.p < 1) ? 1 : v.p;
        runs  = (RETRY_ON != 0 && v.exp_tot < v.min_sp) ? MAX_RETRY + 1 : 1;
        e.lat = 3 + v.ack_dly + runs * (pmax + N + v.r) + (runs - 1);
        e.win = v.exp_win;
        e.tot = v.exp_tot;
        e.windows = runs;
        e.boost = runs - 1;
        cur_na = v.na; cur_ka = v.ka; cur_nb = v.nb; cur_kb = v.kb; cur_all = v.all_ones;
        bus.present_cycles = v.p;
        bus.rest_cycles    = v.r;
        bus.min_spikes     = 16'(v.min_sp);
        bus.start          = 1'b1;
        sb.push_back(e);
        t0 = edge_no;
        @(negedge clk);
        bus.start = 1'b0;
        chk("image_req_after_start", bus.image_req, 1);
        chk("busy_after_start", bus.busy, 1);
        chk("winner_valid_cleared", bus.winner_valid, 0);
        stall_bad = 0;
        for (int i = 0; i < v.ack_dly; i++) begin
            bus.start = (i % 5 == 2);
            @(negedge clk);
            if (bus.image_req !== 1'b1 || bus.net_reset !== 1'b0 ||
                bus.generator_enable !== 1'b0 || bus.neuron_en !== 1'b0) stall_bad++;
        end
        bus.start = 1'b0;
        chk("stall_outputs", stall_bad, 0);
        bus.image_ack = 1'b1;
        @(negedge clk);
        bus.image_ack = 1'b0;
        chk("net_reset_after_ack", bus.net_reset, 1);
        chk("image_req_dropped", bus.image_req, 0);
        windows = 0; reqs = 0; rests = 0; gen_cycles = 0; max_boost = 0;
        got = 1'b0; prev_gen = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (bus.generator_enable && !prev_gen) windows++;
            prev_gen = bus.generator_enable;
            if (bus.generator_enable) gen_cycles++;
            if (bus.neuron_en && !bus.generator_enable) rests++;
            if (bus.image_req) reqs++;
            if (int'(bus.intensity_boost) > max_boost) max_boost = int'(bus.intensity_boost);
            if (bus.done) got = 1'b1;
        end
        chk("done_seen", got, 1);
        g = sb.pop_front();
        if (got) begin
            chk("latency", edge_no - t0, g.lat);
            chk("winner_idx", bus.winner_idx, g.win);
            chk("total_spikes", bus.total_spikes, g.tot);
            chk("winner_valid_at_done", bus.winner_valid, 1);
            chk("present_windows", windows, g.windows);
            chk("present_cycle_count", gen_cycles, g.windows * pmax);
            chk("rest_cycle_count", rests, g.windows * v.r);
            chk("extra_image_req", reqs, 0);
            chk("boost_peak", max_boost, g.boost);
            chk("boost_at_done", bus.intensity_boost, g.boost);
            if (v.b2b) bus.start = 1'b1;
            @(negedge clk);
            chk("done_one_cycle", bus.done, 0);
            chk("idle_not_busy", bus.busy, 0);
            chk("winner_hold", bus.winner_idx, g.win);
            chk("winner_valid_hold", bus.winner_valid, 1);
        end
    endtask

    initial begin
        vec_t nom;
        bus.start = 1'b0;
        bus.image_ack = 1'b0;
        bus.present_cycles = '0;
        bus.rest_cycles = '0;
        bus.min_spikes = '0;

        //          p    r  ack min na ka  nb kb all b2b win tot
        vecs[0] = '{10,   5, 0,  0, 37, 4,  2, 3, 0, 1, 37, 7};
        vecs[1] = '{8,    2, 0,  0, 5,  3, 60, 3, 0, 0, 5,  6};
        vecs[2] = '{0,    3, 1,  0, 9,  5,  0, 0, 0, 0, 9,  1};
        vecs[3] = '{4,    0, 0,  0, 99, 2,  0, 0, 0, 0, 99, 2};
        vecs[4] = '{3,    1, 20, 0, 50, 3, 51, 3, 0, 0, 50, 6};
        vecs[5] = '{2,    1, 0,  5, 0,  0,  0, 0, 0, 0, 0,  0};
        vecs[6] = '{300,  0, 0,  0, 0,  0,  0, 0, 1, 0, 0,  30000};

        repeat (3) @(negedge clk);
        chk("reset_outputs", out_vec(), 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", out_vec(), 0);

        for (int i = 0; i < 7; i++) run_image(vecs[i]);

        // Asynchronous reset in the middle of a presentation.
        nom = vecs[0];
        nom.b2b = 1'b0;
        cur_na = 10; cur_ka = 50; cur_nb = 0; cur_kb = 0; cur_all = 1'b0;
        bus.present_cycles = 50;
        bus.rest_cycles = 5;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.image_ack = 1'b1;
        @(negedge clk);
        bus.image_ack = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_present_gen_en", bus.generator_enable, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", out_vec(), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", out_vec(), 0);
        run_image(nom);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/snn_presentation_sequencer.md
# snn_presentation_sequencer

Controls the presentation of each image to the SNN core, which contains the excitatory and inhibitory layers and the Poisson/LFSR input encoder. For every image it performs these steps in order: image-load handshake, network reset, a fixed number of presentation cycles, a winner scan over per-neuron spike counters, and a rest period. It drives the core's `generator_enable`, `en` and active-high `reset`. It also reports the winning neuron to the training and inference harness.

## Interface
- `NUM_NEURONS`, 100: width of the excitatory spike vector and number of spike counters.
- `CNT_WIDTH`, 8: width of each per-neuron spike counter; counters saturate.
- `MAX_RETRY`, 4: maximum number of low-activity re-presentations per image.
- `clk` (in, 1): the single clock.
- `reset_n` (in, 1): asynchronous, active-low reset.
- `start` (in, 1): requests a presentation; accepted only in IDLE.
- `present_cycles` (in, 32): presentation length P, latched when `start` is accepted.
- `rest_cycles` (in, 32): rest length R, latched when `start` is accepted.
- `min_spikes` (in, 16): minimum total excitatory spikes per presentation, latched when `start` is accepted.
- `image_ack` (in, 1): the image array is stable on the encoder inputs.
- `exc_spikes` (in, NUM_NEURONS): excitatory-layer spike vector.
- `image_req` (out, 1): requests the next image.
- `net_reset` (out, 1): active-high reset to the SNN core.
- `generator_enable` (out, 1): input encoder enable.
- `neuron_en` (out, 1): neuron enable.
- `busy` (out, 1): high whenever the state is not IDLE.
- `done` (out, 1): one-cycle completion pulse.
- `winner_valid` (out, 1): `winner_idx` is valid.
- `winner_idx` (out, $clog2(NUM_NEURONS)): index of the neuron with the most spikes.
- `total_spikes` (out, 16): total excitatory spikes in the last presentation; saturates.
- `intensity_boost` (out, 3): retry level, used by the encoder to raise input rates.

## Operation
- **States:** IDLE, LOAD, NET_RST, PRESENT, EVAL, REST, DONE.
- **IDLE:**
  - `start`=1 latches P, R and `min_spikes`.
  - Clears `winner_valid`, `intensity_boost` and the retry counter.
  - Goes to LOAD.
- **LOAD:**
  - `image_req`=1 until `image_ack` is sampled high.
  - Then goes to NET_RST.
- **NET_RST:**
  - `net_reset`=1 for exactly one cycle.
  - Clears all spike counters and `total_spikes`.
  - Goes to PRESENT.
- **PRESENT:**
  - `generator_enable`=1 and `neuron_en`=1 for exactly max(P,1) cycles.
  - Each cycle, every set bit of `exc_spikes` increments its counter.
  - `total_spikes` increases by the population count of `exc_spikes`.
  - Goes to EVAL.
- **EVAL:**
  - Sequential argmax scan, one counter per cycle, lasting exactly NUM_NEURONS cycles.
  - Both enables are 0.
  - A strictly greater count replaces the current best, so ties resolve to the lowest index.
  - If every count is 0, the winner is index 0.
  - At the end of the scan, the state goes to REST, or to the retry path when the retry feature is compiled in.
- **REST:**
  - `neuron_en`=1 and `generator_enable`=0 for R cycles, so potentials decay.
  - R=0 skips REST entirely.
  - Then goes to DONE, or to NET_RST on the retry path.
- **DONE:**
  - `done`=1 for one cycle.
  - `winner_valid`=1; it holds, together with `winner_idx` and `total_spikes`, until the next accepted `start`.
  - Returns to IDLE.
- **Saturation:** counters stop at 2^CNT_WIDTH−1 and `total_spikes` stops at 65535.
- **Ignored inputs:**
  - `start` is ignored while busy.
  - `exc_spikes` is ignored outside PRESENT.
  - `image_ack` is ignored outside LOAD.
- **Reset mid-operation:** `reset_n` low asserted at any point returns the block to IDLE. All outputs, counters and latched parameters go to 0.

## Timing
- **Reset values:** every output is 0.
- **State outputs:** all outputs are registered and change on the clock edge at which the state is entered.
- **Start to request:** `start` sampled at edge T gives `image_req`=1 from T+1.
- **Request to reset:** `image_ack` sampled at edge A gives `net_reset`=1 during the cycle after A.
- **Presentation start:** PRESENT begins on the cycle after NET_RST.
- **Latency without retry:** from accepted `start` to `done` is 3 + (ack wait) + max(P,1) + NUM_NEURONS + R cycles.
- **Retry window:** the retry decision is made in the last EVAL cycle. NET_RST follows after REST, or immediately when R=0.
- **Back-to-back images:** `start` may be asserted during the `done` cycle. It is sampled in IDLE on the following edge.

## Configuration
- **Macro:** `SNN_SEQ_RETRY_EN`.
- **Defined:**
  - At the end of EVAL, if `total_spikes` < `min_spikes` and the retry count < MAX_RETRY, the retry path is taken.
  - The retry path increments the retry count and `intensity_boost`, passes through REST, then NET_RST, then PRESENT with the same image and no new `image_req`.
  - If the limit is reached, DONE is still reached with the current winner.
- **Undefined:**
  - EVAL always proceeds to REST and then DONE.
  - `intensity_boost` is tied to 0.
  - `min_spikes` is unused.

## Test plan
- **Nominal run:** P=10, R=5, NUM_NEURONS=100, immediate ack, neuron 37 spiking on 4 cycles and neuron 2 on 3 cycles.
  - `done` arrives 118 cycles after `start`.
  - `winner_idx`=37, `total_spikes`=7.
- **Tie-break and zero edges:** neurons 5 and 60 each spike 3 times → `winner_idx`=5. With P=0, exactly one PRESENT cycle occurs. With R=0, REST is absent.
- **Handshake stall:** `image_ack` delayed 20 cycles → `image_req` stays high throughout, with no enables and no `net_reset`. `start` pulses while busy are ignored.
- **Retry (macro defined):** `min_spikes`=5, no spikes at all.
  - Exactly 4 retries, with `intensity_boost` reaching 4.
  - 5 PRESENT windows and a single `image_req`.
  - `done` with `winner_idx`=0.
- **Saturation:** `exc_spikes` all ones for 300 cycles with CNT_WIDTH=8 → every counter is 255, `total_spikes`=30000, `winner_idx`=0.
- **Async reset:** `reset_n` pulled low mid-PRESENT → all outputs are 0 immediately. After release, the next `start` runs a clean presentation.
